// File: rtl/wb_regfile_pkg.sv
// Shared sizing and types for the writeback register file and its scoreboard.
// Defines `XMSB (PC MSB) when the surrounding build has not already done so.
`ifndef XMSB
`define XMSB 63
`endif

package wb_rf_pkg;

  localparam int NREG   = 32;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 2;

  typedef logic [4:0]       reg_idx_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// Per-register pending-write counters (issue increments, writeback decrements)
// with two busy read ports used by decode for RAW stall detection.
module rf_scoreboard
  import wb_rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       iss_valid,
  input  logic [4:0] iss_rd,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       flush,
  input  logic [4:0] rs1_idx,
  input  logic [4:0] rs2_idx,
  output logic       rs1_busy,
  output logic       rs2_busy
);

  sb_cnt_t cnt [NREG];

  function automatic sb_cnt_t next_cnt(sb_cnt_t c, logic inc, logic dec, logic flsh);
    if (flsh)                                  return '0;
    if (inc && !dec && c != CNT_MAX)           return sb_cnt_t'(c + 1'b1);
    if (dec && !inc && c != '0)                return sb_cnt_t'(c - 1'b1);
    return c;
  endfunction

  // The writer retiring this cycle is already forwarded, so it is not a hazard.
  function automatic logic busy_of(sb_cnt_t c, reg_idx_t idx, logic wv, reg_idx_t wrd);
    return (idx != '0) &&
           ((c > sb_cnt_t'(1)) || (c == sb_cnt_t'(1) && !(wv && wrd == idx)));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[reg_idx_t'(r)] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        cnt[reg_idx_t'(r)] <= next_cnt(cnt[reg_idx_t'(r)],
                                       iss_valid && iss_rd == reg_idx_t'(r),
                                       wb_valid  && wb_rd  == reg_idx_t'(r),
                                       flush);
      end
    end
  end

  assign rs1_busy = busy_of(cnt[rs1_idx], rs1_idx, wb_valid, wb_rd);
  assign rs2_busy = busy_of(cnt[rs2_idx], rs2_idx, wb_valid, wb_rd);

`ifndef SYNTHESIS
  logic sb_underflow;
  logic sb_overflow;

  assign sb_underflow = wb_valid && wb_rd != '0 && !(iss_valid && iss_rd == wb_rd) &&
                        cnt[wb_rd] == '0;
  assign sb_overflow  = iss_valid && iss_rd != '0 && !(wb_valid && wb_rd == iss_rd) &&
                        cnt[iss_rd] == CNT_MAX;

  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!sb_underflow);
      assert (!sb_overflow);
    end
  end
`endif

endmodule

// File: rtl/wb_regfile.sv
// Writeback commit into the 32x64 integer register file, two bypassed read ports,
// pending-write scoreboard. Define WB_REGFILE_INSTRET_EN to add the instret counter.
module wb_regfile
  import wb_rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [`XMSB:0]    wb_pc,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  input  logic              flush,
  input  logic [4:0]        rs1_idx,
  input  logic [4:0]        rs2_idx,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [`XMSB:0]    last_pc
`ifdef WB_REGFILE_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[reg_idx_t'(r)] <= '0;
      last_pc <= '0;
    end else if (wb_valid) begin
      if (wb_rd != '0) regs[wb_rd] <= wb_data;
      last_pc <= wb_pc;
    end
  end

  // Same-cycle write-through so decode never waits for the storage update.
  assign rs1_data = (rs1_idx == '0)                  ? '0      :
                    (wb_valid && wb_rd == rs1_idx)   ? wb_data : regs[rs1_idx];
  assign rs2_data = (rs2_idx == '0)                  ? '0      :
                    (wb_valid && wb_rd == rs2_idx)   ? wb_data : regs[rs2_idx];

  rf_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .flush    (flush),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

`ifdef WB_REGFILE_INSTRET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           instret <= '0;
    else if (wb_valid) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/bypass, x0, scoreboard, flush, async reset.
`ifndef XMSB
`define XMSB 63
`endif

module tb_wb_regfile;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic [`XMSB:0]    wb_pc;
  logic [4:0]        wb_rd;
  logic [63:0]       wb_data;
  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic              flush;
  logic [4:0]        rs1_idx;
  logic [4:0]        rs2_idx;
  logic [63:0]       rs1_data;
  logic [63:0]       rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [`XMSB:0]    last_pc;
`ifdef WB_REGFILE_INSTRET_EN
  logic [63:0]       instret;
`endif

  int total = 0;
  int bad   = 0;

  wb_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_pc    (wb_pc),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .flush    (flush),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .last_pc  (last_pc)
`ifdef WB_REGFILE_INSTRET_EN
    ,
    .instret  (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_rd = '0; wb_data = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0; rs1_idx = 5'd5; rs2_idx = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_rs1_data", rs1_data, 64'd0);
    chk("reset_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    chk("reset_last_pc", last_pc, 64'd0);
`ifdef WB_REGFILE_INSTRET_EN
    chk("reset_instret", instret, 64'd0);
`endif

    // write x5 with bypass, then read from storage
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234; wb_pc = 64'h8000_0000;
    #1;
    chk("bypass_x5", rs1_data, 64'h1234);
    chk("bypass_x5_busy", {63'd0, rs1_busy}, 64'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("stored_x5", rs1_data, 64'h1234);
    chk("last_pc_x5", last_pc, 64'h8000_0000);

    // x0 is never written but the instruction still retires
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hFFFF; wb_pc = 64'h8000_0010; rs2_idx = 5'd0;
    #1;
    chk("x0_bypass", rs2_data, 64'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("x0_stored", rs2_data, 64'd0);
    chk("x0_last_pc", last_pc, 64'h8000_0010);
    chk("x5_untouched", rs1_data, 64'h1234);

    // two in-flight writers to x7
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    tick();
    iss_valid = 1'b0; rs1_idx = 5'd7; rs2_idx = 5'd8;
    #1;
    chk("x7_busy_2", {63'd0, rs1_busy}, 64'd1);
    chk("x8_idle", {63'd0, rs2_busy}, 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h77; wb_pc = 64'h8000_0020;
    #1;
    chk("x7_busy_first_wb", {63'd0, rs1_busy}, 64'd1);
    chk("x7_bypass_first", rs1_data, 64'h77);
    tick();
    wb_data = 64'h777; wb_pc = 64'h8000_0024;
    #1;
    chk("x7_busy_last_wb", {63'd0, rs1_busy}, 64'd0);
    chk("x7_bypass_last", rs1_data, 64'h777);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("x7_busy_after", {63'd0, rs1_busy}, 64'd0);
    chk("x7_stored", rs1_data, 64'h777);

    // simultaneous issue and writeback to x9, then flush
    rs1_idx = 5'd9; rs2_idx = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h99; wb_pc = 64'h8000_0028;
    #1;
    chk("x9_busy_incdec_cycle", {63'd0, rs1_busy}, 64'd0);
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("x9_busy_held_rs1", {63'd0, rs1_busy}, 64'd1);
    chk("x9_busy_held_rs2", {63'd0, rs2_busy}, 64'd1);
    chk("x9_stored", rs1_data, 64'h99);
    flush = 1'b1;
    #1;
    chk("x9_busy_before_flush_edge", {63'd0, rs1_busy}, 64'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("x9_flushed_rs1", {63'd0, rs1_busy}, 64'd0);
    chk("x9_flushed_rs2", {63'd0, rs2_busy}, 64'd0);

    // asynchronous reset mid-run
    iss_valid = 1'b1; iss_rd = 5'd10;
    tick();
    iss_rd = 5'd5;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hAA; wb_pc = 64'h8000_0030;
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0; rs1_idx = 5'd5; rs2_idx = 5'd10;
    #1;
    chk("pre_rst_x5", rs1_data, 64'hAA);
    chk("pre_rst_x10_busy", {63'd0, rs2_busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_x5", rs1_data, 64'd0);
    chk("async_rst_busy_rs1", {63'd0, rs1_busy}, 64'd0);
    chk("async_rst_busy_x10", {63'd0, rs2_busy}, 64'd0);
    chk("async_rst_last_pc", last_pc, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef WB_REGFILE_INSTRET_EN
    #1;
    chk("instret_after_rst", instret, 64'd0);
    wb_rd = 5'd0;
    for (int i = 0; i < 13; i++) begin
      wb_valid = !(i == 3 || i == 7 || i == 11);
      wb_pc = 64'h8000_1000 + 64'(i * 4);
      tick();
    end
    wb_valid = 1'b0;
    #1;
    chk("instret_10", instret, 64'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("instret_flush", instret, 64'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
